// File: rtl/dna_pkg.sv
// Shared definitions for the short-read window aligner: base codes,
// controller states and scan mode encodings.
package dna_pkg;

   localparam logic [1:0] BASE_A = 2'b00;
   localparam logic [1:0] BASE_G = 2'b01;
   localparam logic [1:0] BASE_C = 2'b10;
   localparam logic [1:0] BASE_T = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_FIRST = 1'b0;
   localparam logic MODE_BEST  = 1'b1;

endpackage

// File: rtl/window_mismatch_count.sv
// Combinational mismatch counter: number of base positions where the two
// 2-bit-encoded sequences carry different codes.
module window_mismatch_count #(
   parameter int READ_LEN = 10,
   parameter int MM_W     = $clog2(READ_LEN + 1)
) (
   input  logic [2*READ_LEN-1:0] window,
   input  logic [2*READ_LEN-1:0] read,
   output logic [MM_W-1:0]       mm
);

   logic [READ_LEN-1:0] diff;

   // one compare per base; base order does not matter for a popcount
   for (genvar i = 0; i < READ_LEN; i++) begin : g_base
      assign diff[i] = (window[2*i +: 2] != read[2*i +: 2]);
   end

   // popcount of the per-base differences
   always_comb begin
      mm = '0;
      for (int i = 0; i < READ_LEN; i++) begin
         mm = mm + MM_W'(diff[i]);
      end
   end

endmodule

// File: rtl/basepair_window_aligner.sv
// Short-read aligner: slides a READ_LEN window over a latched reference one
// base per clock, counts mismatches, and reports the first or the best window
// that stays within the mismatch tolerance.
module basepair_window_aligner
   import dna_pkg::*;
#(
   parameter int REF_LEN  = 50,
   parameter int READ_LEN = 10,
   parameter int IDX_W    = $clog2(REF_LEN),
   parameter int MM_W     = $clog2(READ_LEN + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  mode,
   input  logic [MM_W-1:0]       max_mismatch,
   input  logic [2*REF_LEN-1:0]  reference,
   input  logic [2*READ_LEN-1:0] shortread,
   output logic                  busy,
   output logic                  done,
   output logic                  found,
   output logic [IDX_W-1:0]      index,
   output logic [2*READ_LEN-1:0] match_seq,
   output logic [MM_W-1:0]       mismatches,
   output logic [IDX_W:0]        match_count
);

   // position of the final window (N-1)
   localparam logic [IDX_W-1:0] LAST = IDX_W'(REF_LEN - READ_LEN);

   state_t                state;
   logic [IDX_W-1:0]      pos;
   logic [2*REF_LEN-1:0]  ref_q;     // shifted left one base per window
   logic [2*READ_LEN-1:0] read_q;
   logic [MM_W-1:0]       maxmm_q;
   logic                  mode_q;

   logic [2*READ_LEN-1:0] win;
   logic [MM_W-1:0]       win_mm;
   logic                  qual;
   logic                  last;
   logic                  better;

   // current window is always the top READ_LEN bases of the shifted copy
   assign win    = ref_q[2*REF_LEN-1 -: 2*READ_LEN];
   assign qual   = (win_mm <= maxmm_q);
   assign last   = (pos == LAST);
   // earliest window wins ties, so only a strictly smaller count replaces
   assign better = !found || (win_mm < mismatches);

   window_mismatch_count #(
      .READ_LEN (READ_LEN),
      .MM_W     (MM_W)
   ) u_mm (
      .window (win),
      .read   (read_q),
      .mm     (win_mm)
   );

   // controller: operand latch, window scan and result recording
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pos         <= '0;
         ref_q       <= '0;
         read_q      <= '0;
         maxmm_q     <= '0;
         mode_q      <= MODE_FIRST;
         busy        <= 1'b0;
         done        <= 1'b0;
         found       <= 1'b0;
         index       <= '0;
         match_seq   <= '0;
         mismatches  <= '0;
         match_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  ref_q       <= reference;
                  read_q      <= shortread;
                  maxmm_q     <= max_mismatch;
                  mode_q      <= mode;
                  pos         <= '0;
                  found       <= 1'b0;
                  index       <= '0;
                  match_seq   <= '0;
                  mismatches  <= '0;
                  match_count <= '0;
                  busy        <= 1'b1;
                  state       <= SCAN;
               end
            end
            SCAN: begin
               pos   <= pos + 1'b1;
               ref_q <= ref_q << 2;
               if (mode_q == MODE_BEST) begin
                  if (qual) begin
                     match_count <= match_count + 1'b1;
                     if (better) begin
                        found      <= 1'b1;
                        index      <= pos;
                        match_seq  <= win;
                        mismatches <= win_mm;
                     end
                  end
                  if (last) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end else begin
                  if (qual) begin
                     found      <= 1'b1;
                     index      <= pos;
                     match_seq  <= win;
                     mismatches <= win_mm;
                  end
                  if (qual || last) begin
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_basepair_window_aligner.sv
// Scoreboard bench for basepair_window_aligner: a behavioural model predicts
// each alignment, a monitor compares whenever done pulses.
module tb_basepair_window_aligner;
   import dna_pkg::*;

   localparam int RL = 50;
   localparam int SL = 10;
   localparam int IW = $clog2(RL);
   localparam int MW = $clog2(SL + 1);
   localparam int NW = RL - SL + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic          mode = 1'b0;
   logic [MW-1:0] max_mismatch = '0;
   logic [2*RL-1:0] reference = '0;
   logic [2*SL-1:0] shortread = '0;
   logic          busy, done, found;
   logic [IW-1:0] index;
   logic [2*SL-1:0] match_seq;
   logic [MW-1:0] mismatches;
   logic [IW:0]   match_count;

   // second instance: REF_LEN = READ_LEN = 8, a single window
   logic          start2 = 1'b0;
   logic          mode2 = 1'b0;
   logic [3:0]    max2 = '0;
   logic [15:0]   ref2 = '0;
   logic [15:0]   read2 = '0;
   logic          busy2, done2, found2;
   logic [2:0]    index2;
   logic [15:0]   seq2;
   logic [3:0]    mm2;
   logic [3:0]    cnt2;

   basepair_window_aligner #(.REF_LEN(RL), .READ_LEN(SL)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode),
      .max_mismatch(max_mismatch), .reference(reference), .shortread(shortread),
      .busy(busy), .done(done), .found(found), .index(index),
      .match_seq(match_seq), .mismatches(mismatches), .match_count(match_count)
   );

   basepair_window_aligner #(.REF_LEN(8), .READ_LEN(8)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .mode(mode2),
      .max_mismatch(max2), .reference(ref2), .shortread(read2),
      .busy(busy2), .done(done2), .found(found2), .index(index2),
      .match_seq(seq2), .mismatches(mm2), .match_count(cnt2)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      bit            found;
      int            index;
      logic [2*SL-1:0] seq;
      int            mm;
      int            cnt;
      int            t0;
      int            tdone;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int passed = 0;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] req);
      total++;
      if (act === req) passed++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
   endtask

   function automatic logic [1:0] code(byte c);
      case (c)
         "A": return BASE_A;
         "G": return BASE_G;
         "C": return BASE_C;
         default: return BASE_T;
      endcase
   endfunction

   function automatic logic [2*SL-1:0] enc(string s);
      logic [2*SL-1:0] v;
      v = '0;
      for (int i = 0; i < SL; i++) v[2*(SL-1-i) +: 2] = code(s[i]);
      return v;
   endfunction

   function automatic logic [2*RL-1:0] fill(logic [1:0] b);
      logic [2*RL-1:0] r;
      for (int i = 0; i < RL; i++) r[2*i +: 2] = b;
      return r;
   endfunction

   // copy the read into the reference at base p, inverting bases listed in flip
   function automatic logic [2*RL-1:0] place(logic [2*RL-1:0] r, logic [2*SL-1:0] s,
                                              int p, logic [SL-1:0] flip);
      logic [2*RL-1:0] o;
      o = r;
      for (int k = 0; k < SL; k++)
         o[2*(RL-1-(p+k)) +: 2] = s[2*(SL-1-k) +: 2] ^ (flip[k] ? 2'b11 : 2'b00);
      return o;
   endfunction

   // reference model: score every window, then pick first or best
   function automatic exp_t model(logic [2*RL-1:0] r, logic [2*SL-1:0] s,
                                  bit md, int mx, int t0);
      exp_t e;
      int   m;
      logic [2*SL-1:0] w;
      e.found = 0; e.index = 0; e.seq = '0; e.mm = 0; e.cnt = 0;
      e.t0 = t0; e.tdone = t0 + NW;
      for (int p = 0; p < NW; p++) begin
         m = 0;
         for (int b = 0; b < SL; b++) begin
            w[2*(SL-1-b) +: 2] = r[2*(RL-1-(p+b)) +: 2];
            if (r[2*(RL-1-(p+b)) +: 2] != s[2*(SL-1-b) +: 2]) m++;
         end
         if (m <= mx) begin
            e.cnt++;
            if (!e.found || m < e.mm) begin
               e.found = 1; e.index = p; e.seq = w; e.mm = m;
            end
            if (!md) begin
               e.cnt = 0;
               e.tdone = t0 + p + 1;
               return e;
            end
         end
      end
      if (!md) e.cnt = 0;
      return e;
   endfunction

   // monitor: busy every cycle, full result check on every done pulse
   initial begin
      exp_t e;
      bit   exp_busy;
      forever begin
         @(negedge clk);
         if (reset) continue;
         exp_busy = (q.size() > 0) && (cyc >= q[0].t0) && (cyc < q[0].tdone);
         chk("busy", busy, exp_busy);
         if (done) begin
            if (q.size() == 0) begin
               total++;
               $display("FAIL spurious_done: done high at cycle %0d with nothing outstanding", cyc);
            end else begin
               e = q.pop_front();
               chk("done_cycle", cyc, e.tdone);
               chk("found", found, e.found);
               chk("index", index, e.index);
               chk("sequence", match_seq, e.seq);
               chk("mismatches", mismatches, e.mm);
               chk("match_count", match_count, e.cnt);
            end
         end
      end
   end

   // issue one alignment; optional start poke during the scan
   task automatic run_job(logic [2*RL-1:0] r, logic [2*SL-1:0] s, bit md, int mx, int poke);
      int n;
      @(negedge clk);
      reference = r; shortread = s; mode = md; max_mismatch = MW'(mx); start = 1'b1;
      q.push_back(model(r, s, md, mx, cyc + 1));
      @(negedge clk);
      start = 1'b0;
      reference = {$urandom, $urandom, $urandom, $urandom};
      shortread = 20'($urandom);
      mode = ~md;
      max_mismatch = MW'(SL);
      n = 0;
      while (q.size() != 0 && n < 200) begin
         start = (n == poke);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      if (q.size() != 0) begin
         total++;
         $display("FAIL timeout: no done within 200 cycles");
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic spec_chk(string nm, bit f, int idx, int mm);
      chk({nm, "_found"}, found, f);
      chk({nm, "_index"}, index, idx);
      chk({nm, "_mm"}, mismatches, mm);
   endtask

   initial begin
      logic [2*SL-1:0] rd;
      logic [2*RL-1:0] r;
      int t0, n, p;
      rd = enc("GAGTCAGACC");

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_found", found, 0);
      chk("rst_index", index, 0);
      chk("rst_seq", match_seq, 0);
      chk("rst_mm", mismatches, 0);
      chk("rst_cnt", match_count, 0);
      chk("rst_busy2", busy2, 0);
      reset = 1'b0;

      // exact copy at 17
      r = place(fill(BASE_T), rd, 17, '0);
      run_job(r, rd, MODE_FIRST, 0, -1);
      spec_chk("exact", 1, 17, 0);
      chk("exact_seq", match_seq, rd);

      // no match anywhere
      r = fill(BASE_A);
      run_job(r, rd, MODE_BEST, 2, -1);
      spec_chk("nomatch", 0, 0, 0);
      chk("nomatch_cnt", match_count, 0);
      run_job(r, rd, MODE_FIRST, 2, -1);

      // tolerance: two altered bases at 30
      r = place(fill(BASE_T), rd, 30, 10'b00_0001_0001);
      run_job(r, rd, MODE_FIRST, 2, -1);
      spec_chk("tol2", 1, 30, 2);
      run_job(r, rd, MODE_FIRST, 1, -1);
      spec_chk("tol1", 0, 0, 0);
      run_job(r, rd, MODE_BEST, 2, -1);
      chk("tol2_only_window", match_count, 1);

      // best vs first
      r = place(place(fill(BASE_T), rd, 5, 10'b00_0000_0100), rd, 30, '0);
      run_job(r, rd, MODE_FIRST, 1, -1);
      spec_chk("first", 1, 5, 1);
      run_job(r, rd, MODE_BEST, 1, -1);
      spec_chk("best", 1, 30, 0);
      chk("best_cnt", match_count, 2);

      // start pulse during a scan is ignored
      run_job(r, rd, MODE_BEST, 1, 5);

      // reset mid-scan after a window has been recorded
      r = place(fill(BASE_T), rd, 3, '0);
      @(negedge clk);
      reference = r; shortread = rd; mode = MODE_BEST; max_mismatch = '0; start = 1'b1;
      t0 = cyc + 1;
      q.push_back(model(r, rd, MODE_BEST, 0, t0));
      @(negedge clk);
      start = 1'b0;
      while (cyc < t0 + 10) @(negedge clk);
      chk("pre_reset_found", found, 1);
      #2 reset = 1'b1;
      q.delete();
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_found", found, 0);
      chk("mid_rst_index", index, 0);
      chk("mid_rst_seq", match_seq, 0);
      chk("mid_rst_mm", mismatches, 0);
      chk("mid_rst_cnt", match_count, 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      run_job(place(fill(BASE_G), rd, 22, '0), rd, MODE_BEST, 0, -1);
      spec_chk("post_rst", 1, 22, 0);

      // randomized planted reads
      for (int j = 0; j < 20; j++) begin
         for (int i = 0; i < RL; i++) r[2*i +: 2] = 2'($urandom);
         rd = 20'($urandom);
         p = $urandom_range(0, NW - 1);
         r = place(r, rd, p, 10'($urandom) & 10'($urandom) & 10'($urandom));
         run_job(r, rd, 1'($urandom), $urandom_range(0, 3), -1);
      end

      // single-window instance
      for (int j = 0; j < 2; j++) begin
         @(negedge clk);
         read2 = 16'($urandom); ref2 = read2; mode2 = j[0]; max2 = '0; start2 = 1'b1;
         t0 = cyc + 1;
         @(negedge clk);
         start2 = 1'b0;
         ref2 = ~read2;
         n = 0;
         while (!done2 && n < 20) begin @(negedge clk); n++; end
         chk("n1_done_cycle", cyc, t0 + 1);
         chk("n1_found", found2, 1);
         chk("n1_index", index2, 0);
         chk("n1_mm", mm2, 0);
         chk("n1_seq", seq2, read2);
         chk("n1_cnt", cnt2, j);
         @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/basepair_window_aligner.md
# basepair_window_aligner

Parametrised short-read aligner: finds where a short read sits in a 2-bit-encoded reference by sliding a window one base per clock and counting per-base mismatches. Successor to the fixed 50-base/10-base exact-match indexer. Adds generic lengths, a runtime mismatch tolerance, first-match and best-match modes, a match counter and a start/done handshake. Sits between read loading and the result/display path of the mapping pipeline.

## Interface
- REF_LEN, 50: reference length in bases.
- READ_LEN, 10: short-read length in bases. Must satisfy 1 ≤ READ_LEN ≤ REF_LEN.
- IDX_W, $clog2(REF_LEN): width of window index.
- MM_W, $clog2(READ_LEN+1): width of mismatch count.
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin alignment. Sampled only in IDLE.
- mode  in  1  0 = first match (early exit), 1 = best match (full scan).
- max_mismatch  in  MM_W  tolerated mismatches, latched at start.
- reference  in  2*REF_LEN  base 0 in the top two bits, base i in bits [2*(REF_LEN-1-i)+1 -: 2]. Latched at start.
- shortread  in  2*READ_LEN  same ordering. Latched at start.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse when results are final.
- found  out  1  a window met the threshold.
- index  out  IDX_W  start base of the reported window.
- sequence  out  2*READ_LEN  reference bases of the reported window.
- mismatches  out  MM_W  mismatch count of the reported window.
- match_count  out  IDX_W+1  windows meeting the threshold. Mode 1 only; 0 in mode 0.

## Operation
- Encoding: A=00, G=01, C=10, T=11. A base mismatches when its 2-bit codes differ.
- N = REF_LEN-READ_LEN+1 windows, positions 0..N-1.
- FSM states and transitions:
  - IDLE: on start, latch inputs, clear all result outputs, set pos=0, go to SCAN.
  - SCAN: each cycle evaluate window pos. A window qualifies when mm ≤ max_mismatch.
    - Mode 0: on the first qualifying window, record it and go to DONE. Otherwise pos++, and at pos=N-1 go to DONE.
    - Mode 1: record a qualifying window if nothing is recorded yet, or if mm < recorded mismatches (earliest wins ties). Increment match_count on every qualifying window. Go to DONE after pos=N-1.
  - DONE: done=1 for one cycle, then go to IDLE.
- Results hold until the next accepted start.
- If nothing qualifies: found=0, index=0, sequence=0, mismatches=0.
- start while in SCAN or DONE is ignored. Input changes after start are ignored.
- Reset (any state): IDLE, and every output is 0.

## Timing
- Edge E0 samples start. Window p is evaluated and registered at edge E(p+1).
- Mode 0, match at p: done is high in the cycle after E(p+1).
- Full scan (mode 1, or mode 0 with no match): done is high in the cycle after E(N). For the defaults, N=41.
- busy is high from after E0 until the transition to DONE.
- found, index, sequence and mismatches are valid no later than the cycle in which done is high.
- Next start is accepted in the first IDLE cycle after done. Throughput is one alignment per N+2 cycles worst case.
- Mismatch count is computed combinationally from the registered window. No additional pipeline stage.

## Structure
- Package dna_pkg:
  - base constants BASE_A/G/C/T
  - state enum IDLE/SCAN/DONE
  - mode constants MODE_FIRST/MODE_BEST
- Sub-module window_mismatch_count, parametrised on READ_LEN:
  - inputs: two 2*READ_LEN vectors
  - output: MM_W popcount of unequal base pairs
  - purely combinational
- The top level holds the FSM, position counter, latched operands and result registers.

## Test plan
- Exact, mode 0, max 0: shortread = GAGTCAGACC placed at base 17 of an all-T reference. Required: found=1, index=17, mismatches=0, sequence=shortread, done after E18.
- No match: all-A reference, read GAGTCAGACC, max 2. Required: found=0, index=0, match_count=0 in mode 1, done after E41.
- Tolerance: as the exact-match scenario but with 2 read bases altered in the reference copy at 30. Required with max 2: found=1, index=30, mismatches=2. Required with max 1: found=0. The bench checks that no other window is ≤ 2.
- Best vs first: a 1-mismatch copy at 5 and an exact copy at 30, max 1. Required in mode 0: index=5, mismatches=1, done after E6. Required in mode 1: index=30, mismatches=0, match_count=2, done after E41.
- Reset mid-scan and busy start: assert reset at pos 10. Required: all outputs 0 immediately, then a new alignment runs correctly. A start pulse during SCAN is ignored.
- Generic lengths: REF_LEN=8, READ_LEN=8, exact read. Required: N=1, index=0, done after E1.
